// File: rtl/display_shift_driver_pkg.sv
// Shared types and constant helpers for the display shift-chain driver.
package display_shift_driver_pkg;

    typedef enum logic [2:0] {
        ST_CLR,
        ST_IDLE,
        ST_SHIFT,
        ST_LOAD,
        ST_DONE
    } state_t;

    // Bits needed to hold values 0 .. value-1; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/display_shift_driver_bit_timer.sv
// Shift-clock divider: free-runs while enabled, giving the sclk level plus
// strobes on the cycle before each sclk rise and each sclk fall. Cleared to
// zero (sclk low) whenever disabled, so every frame starts with a low phase.
module display_shift_driver_bit_timer #(
    parameter int DIV_LOG2 = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sclk,
    output logic rise,
    output logic fall
);

    localparam int            CW      = DIV_LOG2 + 1;
    localparam logic [CW-1:0] RISE_AT = CW'((1 << DIV_LOG2) - 1);
    localparam logic [CW-1:0] FALL_AT = CW'((1 << CW) - 1);

    logic [CW-1:0] cnt;

    // Phase counter; its MSB is the sclk level, wrapping once per bit period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign sclk = cnt[DIV_LOG2];
    assign rise = en && (cnt == RISE_AT);
    assign fall = en && (cnt == FALL_AT);

endmodule

// File: rtl/display_shift_driver.sv
// Front-panel shift-chain driver: snapshots the display image, shifts it out
// on CHAINS parallel '595-style chains with a shared sclk, then pulses sload.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_CLR   | sclr_n held low for CLR_CYCLES after reset release
// ST_IDLE  | waiting for update, pending request or auto_refresh
// ST_SHIFT | NBITS bits shifted per chain, sdata moves on sclk fall
// ST_LOAD  | sload high for LOAD_CYCLES, sclk low, last bit held
// ST_DONE  | one-cycle done pulse, busy drops on the following cycle
module display_shift_driver
    import display_shift_driver_pkg::*;
#(
    parameter int NBITS       = 72,
    parameter int CHAINS      = 1,
    parameter int DIV_LOG2    = 4,
    parameter int LOAD_CYCLES = 4,
    parameter int CLR_CYCLES  = 16,
    parameter bit MSB_FIRST   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [CHAINS*NBITS-1:0] display_bits,
    input  logic                    update,
    input  logic                    auto_refresh,
    output logic                    busy,
    output logic                    done,
    output logic                    sclk,
    output logic [CHAINS-1:0]       sdata,
    output logic                    sload,
    output logic                    sclr_n
);

    localparam int BCW = clog2(NBITS + 1);
    // One down-counter serves both the clear and the load hold time.
    localparam int TMW = max2(1, clog2(max2(LOAD_CYCLES, CLR_CYCLES)));

    localparam logic [BCW-1:0] BIT_LAST  = BCW'(NBITS);
    localparam logic [TMW-1:0] CLR_INIT  = TMW'(CLR_CYCLES - 1);
    localparam logic [TMW-1:0] LOAD_INIT = TMW'(LOAD_CYCLES - 1);

    state_t                         state;
    logic                           pending;
    logic [BCW-1:0]                 bit_cnt;
    logic [TMW-1:0]                 tmr;
    logic [CHAINS-1:0][NBITS-1:0]   shadow;
    logic [CHAINS-1:0][NBITS-1:0]   shadow_nxt;
    logic [CHAINS-1:0]              first_bit;
    logic [CHAINS-1:0]              next_bit;
    logic                           shift_en;
    logic                           rise;
    logic                           fall;
    logic                           start;

    assign shift_en = (state == ST_SHIFT);
    assign start    = (state == ST_IDLE) && (update || pending || auto_refresh);

    display_shift_driver_bit_timer #(
        .DIV_LOG2 (DIV_LOG2)
    ) u_bit_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (shift_en),
        .sclk  (sclk),
        .rise  (rise),
        .fall  (fall)
    );

    // Per-chain shift direction and the bit that goes out first/next.
    always_comb begin
        shadow_nxt = shadow;
        first_bit  = '0;
        next_bit   = '0;
        for (int c = 0; c < CHAINS; c++) begin
            if (MSB_FIRST) begin
                shadow_nxt[c] = {shadow[c][NBITS-2:0], 1'b0};
                first_bit[c]  = display_bits[c*NBITS + NBITS - 1];
                next_bit[c]   = shadow_nxt[c][NBITS-1];
            end else begin
                shadow_nxt[c] = {1'b0, shadow[c][NBITS-1:1]};
                first_bit[c]  = display_bits[c*NBITS];
                next_bit[c]   = shadow_nxt[c][0];
            end
        end
    end

    // Frame sequencer with request merging and registered pin outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_CLR;
            pending <= 1'b0;
            bit_cnt <= '0;
            tmr     <= CLR_INIT;
            shadow  <= '0;
            sdata   <= '0;
            sload   <= 1'b0;
            sclr_n  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            // Requests outside IDLE are remembered one deep; extra ones merge.
            if (update && (state != ST_IDLE)) begin
                pending <= 1'b1;
            end
            case (state)
                ST_CLR: begin
                    if (tmr == '0) begin
                        sclr_n <= 1'b1;
                        state  <= ST_IDLE;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (start) begin
                        shadow  <= display_bits;
                        sdata   <= first_bit;
                        pending <= 1'b0;
                        busy    <= 1'b1;
                        bit_cnt <= '0;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (rise) begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    // The last fall ends the frame; sdata keeps the final bit.
                    if (fall) begin
                        if (bit_cnt == BIT_LAST) begin
                            sload <= 1'b1;
                            tmr   <= LOAD_INIT;
                            state <= ST_LOAD;
                        end else begin
                            shadow <= shadow_nxt;
                            sdata  <= next_bit;
                        end
                    end
                end
                ST_LOAD: begin
                    if (tmr == '0) begin
                        sload <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_CLR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_display_shift_driver.sv
// Bench for display_shift_driver: an MSB-first and an LSB-first instance share
// stimulus; expected frames are queued per instance and checked by monitors
// that model the external '595 chains.
module tb_display_shift_driver;

    localparam int NBITS       = 8;
    localparam int CHAINS      = 2;
    localparam int DIV_LOG2    = 1;
    localparam int LOAD_CYCLES = 2;
    localparam int CLR_CYCLES  = 3;

    typedef struct {
        logic [15:0] img;
        int          gap;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] display_bits = '0;
    logic        update = 1'b0;
    logic        auto_refresh = 1'b0;

    logic [1:0]      busy_v;
    logic [1:0]      done_v;
    logic [1:0]      sclk_v;
    logic [1:0]      sload_v;
    logic [1:0]      sclr_v;
    logic [1:0][1:0] sdata_v;

    int     errors = 0;
    int     checks = 0;
    int     dones [2];
    int     exp_dones = 0;
    frame_t exp_q0[$];
    frame_t exp_q1[$];

    always #5 clk = ~clk;

    display_shift_driver #(
        .NBITS(NBITS), .CHAINS(CHAINS), .DIV_LOG2(DIV_LOG2),
        .LOAD_CYCLES(LOAD_CYCLES), .CLR_CYCLES(CLR_CYCLES), .MSB_FIRST(1'b1)
    ) dut_msb (
        .clk(clk), .rst_n(rst_n), .display_bits(display_bits), .update(update),
        .auto_refresh(auto_refresh), .busy(busy_v[0]), .done(done_v[0]),
        .sclk(sclk_v[0]), .sdata(sdata_v[0]), .sload(sload_v[0]), .sclr_n(sclr_v[0])
    );

    display_shift_driver #(
        .NBITS(NBITS), .CHAINS(CHAINS), .DIV_LOG2(DIV_LOG2),
        .LOAD_CYCLES(LOAD_CYCLES), .CLR_CYCLES(CLR_CYCLES), .MSB_FIRST(1'b0)
    ) dut_lsb (
        .clk(clk), .rst_n(rst_n), .display_bits(display_bits), .update(update),
        .auto_refresh(auto_refresh), .busy(busy_v[1]), .done(done_v[1]),
        .sclk(sclk_v[1]), .sdata(sdata_v[1]), .sload(sload_v[1]), .sclr_n(sclr_v[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [13:0] all_outputs();
        return {busy_v, done_v, sclk_v, sload_v, sclr_v, sdata_v};
    endfunction

    // Monitors: model the external chains and score each frame as it happens.
    for (genvar d = 0; d < 2; d++) begin : g_mon
        initial begin
            int              cyc;
            int              start_c;
            int              prev_start;
            int              first_rise;
            int              rises;
            int              sload_len;
            logic            p_busy;
            logic            p_sclk;
            logic            p_sload;
            logic            active;
            bit              have;
            frame_t          cur;
            logic [1:0][7:0] chain;
            string           tag;
            cyc = 0; start_c = 0; prev_start = -1; first_rise = -1;
            rises = 0; sload_len = 0;
            p_busy = 0; p_sclk = 0; p_sload = 0; active = 0;
            cur.img = '0; cur.gap = 0; chain = '0;
            tag = (d == 0) ? "msb" : "lsb";
            dones[d] = 0;
            forever begin
                @(negedge clk);
                cyc++;
                if (!rst_n) begin
                    active = 0; p_busy = 0; p_sclk = 0; p_sload = 0; prev_start = -1;
                    continue;
                end
                if (busy_v[d] && !p_busy) begin
                    have = 0;
                    if (d == 0) begin
                        if (exp_q0.size() > 0) begin cur = exp_q0.pop_front(); have = 1; end
                    end else begin
                        if (exp_q1.size() > 0) begin cur = exp_q1.pop_front(); have = 1; end
                    end
                    chk({tag, " frame_expected"}, 32'(have), 1);
                    if (!have) begin cur.img = '0; cur.gap = 0; end
                    if (cur.gap != 0) chk({tag, " frame_period"}, cyc - prev_start, cur.gap);
                    prev_start = cyc; start_c = cyc; first_rise = -1;
                    rises = 0; sload_len = 0; chain = '0; active = 1;
                end
                if (sclk_v[d] && !p_sclk) begin
                    rises++;
                    if (first_rise < 0) first_rise = cyc;
                    for (int c = 0; c < 2; c++) begin
                        if (d == 0) chain[c] = {chain[c][6:0], sdata_v[d][c]};
                        else        chain[c] = {sdata_v[d][c], chain[c][7:1]};
                    end
                end
                if (sload_v[d]) begin
                    sload_len++;
                    if (!p_sload) begin
                        chk({tag, " sclk_low_in_load"}, 32'(sclk_v[d]), 0);
                        chk({tag, " latched_image"}, 32'(chain), 32'(cur.img));
                    end
                end
                if (done_v[d]) begin
                    dones[d]++;
                    chk({tag, " done_in_frame"}, 32'(active), 1);
                    if (active) begin
                        chk({tag, " done_latency"}, cyc - start_c, 34);
                        chk({tag, " first_rise_offset"}, first_rise - start_c, 2);
                        chk({tag, " sclk_rises"}, rises, 8);
                        chk({tag, " sload_len"}, sload_len, 2);
                        chk({tag, " busy_at_done"}, 32'(busy_v[d]), 1);
                    end
                    active = 0;
                end
                p_busy = busy_v[d]; p_sclk = sclk_v[d]; p_sload = sload_v[d];
            end
        end
    end

    task automatic expect_frame(input logic [15:0] img, input int gap);
        frame_t f;
        f.img = img;
        f.gap = gap;
        exp_q0.push_back(f);
        exp_q1.push_back(f);
    endtask

    task automatic pulse_update();
        @(negedge clk); update = 1'b1;
        @(negedge clk); update = 1'b0;
    endtask

    task automatic wait_dones(input int n);
        for (int i = 0; i < 400; i++) begin
            if (dones[0] >= n && dones[1] >= n) break;
            @(negedge clk);
        end
        chk("wait_done_count", 32'(dones[0] >= n && dones[1] >= n), 1);
    endtask

    task automatic check_quiet(input int n_cycles);
        repeat (n_cycles) @(negedge clk);
        chk("queue_drained", exp_q0.size() + exp_q1.size(), 0);
        chk("done_count_msb", dones[0], exp_dones);
        chk("done_count_lsb", dones[1], exp_dones);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("sclr_n_sequence", 32'(sclr_v), (i < 3) ? 32'h0 : 32'h3);
            chk("busy_in_clr", 32'(busy_v), 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'(all_outputs()), 0);
        release_reset();

        // Single frame, checked in both shift orders.
        display_bits = 16'hA53C;
        expect_frame(16'hA53C, 0);
        pulse_update();
        exp_dones = 1;
        wait_dones(1);
        check_quiet(10);

        // Two merged mid-frame requests plus an image change: one extra frame.
        display_bits = 16'h1234;
        expect_frame(16'h1234, 0);
        expect_frame(16'hBEEF, 36);
        pulse_update();
        repeat (8) @(negedge clk);
        display_bits = 16'hBEEF;
        pulse_update();
        repeat (5) @(negedge clk);
        pulse_update();
        exp_dones = 3;
        wait_dones(3);
        check_quiet(60);

        // Request landing in the done cycle becomes pending.
        display_bits = 16'h0F0F;
        expect_frame(16'h0F0F, 0);
        expect_frame(16'hC3A5, 36);
        pulse_update();
        for (int i = 0; i < 100 && !done_v[0]; i++) @(negedge clk);
        chk("done_seen_for_coincident", 32'(done_v[0]), 1);
        update = 1'b1;
        display_bits = 16'hC3A5;
        @(negedge clk);
        update = 1'b0;
        exp_dones = 5;
        wait_dones(5);
        check_quiet(60);

        // Continuous refresh, dropped during the third frame.
        display_bits = 16'h5AA5;
        expect_frame(16'h5AA5, 0);
        expect_frame(16'h5AA5, 36);
        expect_frame(16'h5AA5, 36);
        @(negedge clk);
        auto_refresh = 1'b1;
        exp_dones = 7;
        wait_dones(7);
        repeat (5) @(negedge clk);
        auto_refresh = 1'b0;
        exp_dones = 8;
        wait_dones(8);
        check_quiet(80);

        // Reset in the middle of bit 5: immediate clear, no done, CLR replays.
        display_bits = 16'h9966;
        expect_frame(16'h9966, 0);
        pulse_update();
        repeat (22) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs", 32'(all_outputs()), 0);
        repeat (3) @(negedge clk);
        release_reset();
        check_quiet(60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
